// File: rtl/tl_ul_sram_slave.sv
// TL-UL slave endpoint in front of a single-port synchronous SRAM.
// A-channel requests are checked and sent to the SRAM in the cycle they are
// accepted. The response metadata waits one cycle in a stage register so it
// can pick up the SRAM read data. It is then queued in a small response
// FIFO that drives the D channel. a_ready is granted against credits that
// count both queued entries and the one entry still in the stage.
module tl_ul_sram_slave #(
  parameter int ADDR_W = 30,
  parameter int SRC_W  = 1,
  parameter int DEPTH  = 3
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                a_valid,
  output logic                a_ready,
  input  logic [2:0]          a_opcode,
  input  logic [2:0]          a_param,
  input  logic [1:0]          a_size,
  input  logic [SRC_W-1:0]    a_source,
  input  logic [ADDR_W-1:0]   a_address,
  input  logic [3:0]          a_mask,
  input  logic [31:0]         a_data,
  output logic                d_valid,
  input  logic                d_ready,
  output logic [2:0]          d_opcode,
  output logic [1:0]          d_param,
  output logic [1:0]          d_size,
  output logic [SRC_W-1:0]    d_source,
  output logic                d_denied,
  output logic                d_corrupt,
  output logic [31:0]         d_data,
  output logic                sram_req,
  output logic                sram_we,
  output logic [ADDR_W-3:0]   sram_addr,
  output logic [3:0]          sram_wmask,
  output logic [31:0]         sram_wdata,
  input  logic [31:0]         sram_rdata
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;

  // Request decode
  logic op_ok;
  logic param_ok;
  logic size_ok;
  logic align_ok;
  logic req_legal;
  logic req_is_get;
  logic fire;

  // Stage register: the one response whose SRAM access is in flight
  logic               pend_reg;
  logic               stg_get_reg;
  logic [1:0]         stg_size_reg;
  logic [SRC_W-1:0]   stg_source_reg;
  logic               stg_denied_reg;

  // Response FIFO storage and control
  logic               fifo_get    [DEPTH];
  logic [1:0]         fifo_size   [DEPTH];
  logic [SRC_W-1:0]   fifo_source [DEPTH];
  logic               fifo_denied [DEPTH];
  logic [31:0]        fifo_data   [DEPTH];

  logic [PTR_W-1:0]   head_reg, head_next;
  logic [PTR_W-1:0]   tail_reg, tail_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [CNT_W:0]     credit_used;
  logic               enq;
  logic               deq;
  logic [31:0]        enq_data;

  // Pointer advance with wrap at DEPTH, so DEPTH need not be a power of two
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
    if (ptr == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return ptr + 1'b1;
  endfunction

  // Classify the A-channel request as legal or denied
  always_comb begin
    op_ok    = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART) ||
               (a_opcode == OP_GET);
    param_ok = (a_param == 3'd0);
    size_ok  = (a_size != 2'd3);
    case (a_size)
      2'd0:    align_ok = 1'b1;
      2'd1:    align_ok = ~a_address[0];
      2'd2:    align_ok = (a_address[1:0] == 2'b00);
      default: align_ok = 1'b0;
    endcase
    req_legal  = op_ok && param_ok && size_ok && align_ok;
    req_is_get = (a_opcode == OP_GET);
  end

  // Credits come from registered state only, so d_ready never reaches a_ready
  assign credit_used = {1'b0, count_reg} + (CNT_W + 1)'(pend_reg);
  assign a_ready     = ~reset && (credit_used < (CNT_W + 1)'(DEPTH));
  assign fire        = a_valid && a_ready;

  // Denied requests never touch memory; Gets write no bytes
  assign sram_req   = fire && req_legal;
  assign sram_we    = ~req_is_get;
  assign sram_addr  = a_address[ADDR_W-1:2];
  assign sram_wdata = a_data;

  for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
    assign sram_wmask[gi] = ~req_is_get && a_mask[gi];
  end

  // Capture response metadata while the SRAM access completes
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_reg       <= 1'b0;
      stg_get_reg    <= 1'b0;
      stg_size_reg   <= 2'd0;
      stg_source_reg <= '0;
      stg_denied_reg <= 1'b0;
    end else begin
      pend_reg <= fire;
      if (fire) begin
        stg_get_reg    <= req_is_get;
        stg_size_reg   <= a_size;
        stg_source_reg <= a_source;
        stg_denied_reg <= ~req_legal;
      end
    end
  end

  assign enq      = pend_reg;
  assign deq      = d_valid && d_ready;
  assign enq_data = (stg_get_reg && ~stg_denied_reg) ? sram_rdata : 32'h0;

  // FIFO pointer and occupancy update
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    count_next = count_reg;
    if (enq) begin
      tail_next = ptr_inc(tail_reg);
    end
    if (deq) begin
      head_next = ptr_inc(head_reg);
    end
    case ({enq, deq})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
  end

  // FIFO control registers; reset drops every queued response
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // FIFO payload storage; contents are qualified by count so need no reset
  always_ff @(posedge clock) begin
    if (enq) begin
      fifo_get[tail_reg]    <= stg_get_reg;
      fifo_size[tail_reg]   <= stg_size_reg;
      fifo_source[tail_reg] <= stg_source_reg;
      fifo_denied[tail_reg] <= stg_denied_reg;
      fifo_data[tail_reg]   <= enq_data;
    end
  end

  assign d_valid = (count_reg != '0);
  assign d_param = 2'd0;

  // Present the head entry; payload reads as zero whenever nothing is queued
  always_comb begin
    d_opcode  = 3'd0;
    d_size    = 2'd0;
    d_source  = '0;
    d_denied  = 1'b0;
    d_corrupt = 1'b0;
    d_data    = 32'h0;
    if (d_valid) begin
      d_opcode  = {2'b00, fifo_get[head_reg]};
      d_size    = fifo_size[head_reg];
      d_source  = fifo_source[head_reg];
      d_denied  = fifo_denied[head_reg];
      d_corrupt = fifo_denied[head_reg] && fifo_get[head_reg];
      d_data    = fifo_get[head_reg] ? fifo_data[head_reg] : 32'h0;
    end
  end

endmodule

// File: tb/tb_tl_ul_sram_slave.sv
// Randomized and directed bench for tl_ul_sram_slave. A transaction-level
// model (response queue, byte-addressed reference memory) predicts a_ready,
// SRAM commands and every D-channel response.
module tb_tl_ul_sram_slave;
  localparam int ADDR_W = 30;
  localparam int SRC_W  = 1;
  localparam int DEPTH  = 3;

  logic              clock = 1'b0;
  logic              reset;
  logic              a_valid;
  logic              a_ready;
  logic [2:0]        a_opcode;
  logic [2:0]        a_param;
  logic [1:0]        a_size;
  logic [SRC_W-1:0]  a_source;
  logic [ADDR_W-1:0] a_address;
  logic [3:0]        a_mask;
  logic [31:0]       a_data;
  logic              d_valid;
  logic              d_ready;
  logic [2:0]        d_opcode;
  logic [1:0]        d_param;
  logic [1:0]        d_size;
  logic [SRC_W-1:0]  d_source;
  logic              d_denied;
  logic              d_corrupt;
  logic [31:0]       d_data;
  logic              sram_req;
  logic              sram_we;
  logic [ADDR_W-3:0] sram_addr;
  logic [3:0]        sram_wmask;
  logic [31:0]       sram_wdata;
  logic [31:0]       sram_rdata;

  always #5 clock = ~clock;

  tl_ul_sram_slave #(.ADDR_W(ADDR_W), .SRC_W(SRC_W), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .a_valid(a_valid), .a_ready(a_ready), .a_opcode(a_opcode), .a_param(a_param),
    .a_size(a_size), .a_source(a_source), .a_address(a_address), .a_mask(a_mask),
    .a_data(a_data),
    .d_valid(d_valid), .d_ready(d_ready), .d_opcode(d_opcode), .d_param(d_param),
    .d_size(d_size), .d_source(d_source), .d_denied(d_denied), .d_corrupt(d_corrupt),
    .d_data(d_data),
    .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  // Behavioural SRAM: 64 words, 1-cycle read latency
  logic [31:0] sram_mem [0:63];
  always @(posedge clock) begin
    if (reset) begin
      sram_rdata <= 32'h0;
    end else if (sram_req) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask[b]) sram_mem[sram_addr[5:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr[5:0]];
      end
    end
  end

  // Reference model state
  typedef struct {
    int          t;
    logic        get;
    logic [1:0]  size;
    logic        src;
    logic        denied;
    logic [31:0] data;
  } resp_t;

  resp_t       exp_q[$];
  logic [31:0] ref_mem [0:63];
  int          win;
  int          n_acc;
  int          n_resp;
  logic [31:0] last_data;
  logic [9:0]  last_hdr;
  int          n_checks;
  int          n_errors;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle: drive, predict/check at negedge, update model, advance
  task automatic do_cycle(input logic av, input logic [2:0] op, input logic [2:0] prm,
                          input logic [1:0] sz, input logic src, input logic [29:0] addr,
                          input logic [3:0] msk, input logic [31:0] dat, input logic dr);
    logic  exp_ready, legal, fire_m, exp_dv;
    resp_t r;
    int    idx;
    a_valid = av; a_opcode = op; a_param = prm; a_size = sz; a_source = src;
    a_address = addr; a_mask = msk; a_data = dat; d_ready = dr;
    @(negedge clock);
    exp_ready = (exp_q.size() < DEPTH);
    legal = (op == 3'd0 || op == 3'd1 || op == 3'd4) && prm == 3'd0 && sz <= 2'd2 &&
            ((int'(addr[2:0]) % (1 << int'(sz))) == 0);
    fire_m = av && exp_ready;
    idx = int'(addr[7:2]);
    check_val("a_ready", 32'(a_ready), 32'(exp_ready));
    check_val("sram_req", 32'(sram_req), 32'(fire_m && legal));
    if (fire_m && legal) begin
      check_val("sram_addr", 32'(sram_addr), 32'(addr >> 2));
      check_val("sram_we", 32'(sram_we), 32'(op != 3'd4));
      check_val("sram_wmask", 32'(sram_wmask), (op == 3'd4) ? 32'h0 : 32'(msk));
      check_val("sram_wdata", sram_wdata, dat);
    end
    exp_dv = (exp_q.size() > 0) && (exp_q[0].t + 2 <= win);
    check_val("d_valid", 32'(d_valid), 32'(exp_dv));
    if (exp_dv) begin
      r = exp_q[0];
      check_val("d_hdr", 32'({d_opcode, d_param, d_size, d_source, d_denied, d_corrupt}),
                32'({2'b00, r.get, 2'b00, r.size, r.src, r.denied, r.denied && r.get}));
      check_val("d_data", d_data, r.data);
      if (dr) begin
        last_data = d_data;
        last_hdr  = {d_opcode, d_param, d_size, d_source, d_denied, d_corrupt};
        $display("resp #%0d src=%0d op=%0d size=%0d denied=%0d data=%h",
                 n_resp, d_source, d_opcode, d_size, d_denied, d_data);
        void'(exp_q.pop_front());
        n_resp++;
      end
    end
    if (fire_m) begin
      r.t = win; r.get = (op == 3'd4); r.size = sz; r.src = src; r.denied = !legal;
      r.data = (op == 3'd4 && legal) ? ref_mem[idx] : 32'h0;
      exp_q.push_back(r);
      if (legal && op != 3'd4)
        for (int b = 0; b < 4; b++)
          if (msk[b]) ref_mem[idx][8*b +: 8] = dat[8*b +: 8];
      n_acc++;
    end
    @(posedge clock);
    #1;
    win++;
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++)
      do_cycle(1'b0, 3'd4, 3'd0, 2'd2, 1'b0, 30'h0, 4'h0, 32'h0, 1'b1);
    check_val("drain_empty", 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    int acc0, resp0;
    logic [2:0]  op, prm;
    logic [1:0]  sz;
    logic [29:0] addr;
    logic [31:0] wd;
    n_checks = 0; n_errors = 0; win = 0; n_acc = 0; n_resp = 0;
    last_data = 32'h0; last_hdr = 10'h0;
    a_valid = 1'b0; a_opcode = 3'd0; a_param = 3'd0; a_size = 2'd0; a_source = 1'b0;
    a_address = '0; a_mask = 4'h0; a_data = 32'h0; d_ready = 1'b0;

    // Reset state
    reset = 1'b1;
    #2;
    check_val("rst_a_ready", 32'(a_ready), 32'h0);
    check_val("rst_d_valid", 32'(d_valid), 32'h0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Fill memory with known words through the slave
    for (int w = 0; w < 64; w++) begin
      wd = (w == 17) ? 32'h11223344 : $urandom;
      do_cycle(1'b1, 3'd0, 3'd0, 2'd2, 1'(w), 30'(w * 4), 4'hF, wd, 1'b1);
    end
    drain();

    // PutFull then Get at 0x40
    do_cycle(1'b1, 3'd0, 3'd0, 2'd2, 1'b1, 30'h40, 4'hF, 32'hDEADBEEF, 1'b1);
    do_cycle(1'b1, 3'd4, 3'd0, 2'd2, 1'b0, 30'h40, 4'h0, 32'h0, 1'b1);
    drain();
    check_val("get_0x40", last_data, 32'hDEADBEEF);

    // PutPartial lane 1 over 0x11223344
    do_cycle(1'b1, 3'd1, 3'd0, 2'd2, 1'b0, 30'h44, 4'h2, 32'h0000AB00, 1'b1);
    do_cycle(1'b1, 3'd4, 3'd0, 2'd2, 1'b1, 30'h44, 4'h0, 32'h0, 1'b1);
    drain();
    check_val("partial_get", last_data, 32'h1122AB44);

    // Misaligned Get and unsupported opcode
    do_cycle(1'b1, 3'd4, 3'd0, 2'd2, 1'b1, 30'h42, 4'hF, 32'h0, 1'b1);
    drain();
    check_val("misaligned_hdr", 32'(last_hdr), 32'({3'd1, 2'd0, 2'd2, 1'b1, 1'b1, 1'b1}));
    check_val("misaligned_data", last_data, 32'h0);
    do_cycle(1'b1, 3'd2, 3'd0, 2'd2, 1'b0, 30'h40, 4'hF, 32'h5, 1'b1);
    drain();
    check_val("arith_hdr", 32'(last_hdr), 32'({3'd0, 2'd0, 2'd2, 1'b0, 1'b1, 1'b0}));

    // Back-to-back Gets with d_ready high
    acc0 = n_acc; resp0 = n_resp;
    for (int i = 0; i < 10; i++)
      do_cycle(1'b1, 3'd4, 3'd0, 2'd2, 1'(i), 30'(i * 4), 4'h0, 32'h0, 1'b1);
    check_val("b2b_accepts", 32'(n_acc - acc0), 32'd10);
    drain();
    check_val("b2b_resps", 32'(n_resp - resp0), 32'd10);

    // Backpressure: exactly DEPTH accepted, one slot reopens after one pop
    acc0 = n_acc;
    for (int i = 0; i < 5; i++)
      do_cycle(1'b1, 3'd4, 3'd0, 2'd2, 1'b0, 30'(i * 4), 4'h0, 32'h0, 1'b0);
    check_val("bp_accepts", 32'(n_acc - acc0), 32'd3);
    do_cycle(1'b0, 3'd4, 3'd0, 2'd2, 1'b0, 30'h0, 4'h0, 32'h0, 1'b1);
    acc0 = n_acc;
    do_cycle(1'b1, 3'd4, 3'd0, 2'd2, 1'b1, 30'h8, 4'h0, 32'h0, 1'b0);
    check_val("bp_reopen", 32'(n_acc - acc0), 32'd1);
    drain();

    // Reset with two queued responses and one pending
    for (int i = 0; i < 3; i++)
      do_cycle(1'b1, 3'd4, 3'd0, 2'd2, 1'b0, 30'(i * 4), 4'h0, 32'h0, 1'b0);
    a_valid = 1'b1; a_opcode = 3'd4; a_size = 2'd2; a_address = 30'h0; d_ready = 1'b0;
    reset = 1'b1;
    #1;
    check_val("mid_rst_d_valid", 32'(d_valid), 32'h0);
    check_val("mid_rst_a_ready", 32'(a_ready), 32'h0);
    check_val("mid_rst_d_data", d_data, 32'h0);
    check_val("mid_rst_sram_req", 32'(sram_req), 32'h0);
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++)
      do_cycle(1'b0, 3'd4, 3'd0, 2'd2, 1'b0, 30'h0, 4'h0, 32'h0, 1'b1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2: op = 3'd0;
        3, 4:    op = 3'd1;
        9:       op = 3'($urandom_range(0, 7));
        default: op = 3'd4;
      endcase
      prm  = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      sz   = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr = 30'($urandom_range(0, 63) * 4 +
                 (($urandom_range(0, 5) == 0) ? $urandom_range(1, 3) : 0));
      do_cycle(1'($urandom_range(0, 3) != 0), op, prm, sz, 1'($urandom_range(0, 1)), addr,
               4'($urandom_range(0, 15)), $urandom, 1'($urandom_range(0, 3) != 0));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/tl_ul_sram_slave.md
Name: tl_ul_sram_slave

Overview:
- TileLink-UL slave endpoint; sits directly downstream of the TL-UL A/D link that the bus monitor checks.
- Accepts Get, PutFullData and PutPartialData on the A channel and drives a single-port synchronous SRAM with 1-cycle read latency.
- Returns AccessAck / AccessAckData on the D channel through a credit-managed response FIFO.
- Rejects unsupported or malformed requests with a denied response and never touches memory for them.

Parameters:
- ADDR_W, 30, A-channel byte address width.
- SRC_W, 1, source ID width.
- DEPTH, 3, response FIFO entries. 3 sustains one request per cycle with d_ready held high.

Ports:
- clock  in  1  sole clock
- reset  in  1  asynchronous, active-high reset
- a_valid  in  1  A request valid
- a_ready  out  1  A request accepted when high with a_valid
- a_opcode  in  3  0=PutFullData, 1=PutPartialData, 4=Get; others unsupported
- a_param  in  3  must be 0
- a_size  in  2  log2 bytes; 0..2 legal
- a_source  in  SRC_W  request ID
- a_address  in  ADDR_W  byte address
- a_mask  in  4  byte lanes
- a_data  in  32  write data
- d_valid  out  1  response valid
- d_ready  in  1  response accepted
- d_opcode  out  3  0=AccessAck, 1=AccessAckData
- d_param  out  2  always 0
- d_size  out  2  echo of a_size
- d_source  out  SRC_W  echo of a_source
- d_denied  out  1  request rejected
- d_corrupt  out  1  data invalid
- d_data  out  32  read data
- sram_req  out  1  SRAM access this cycle
- sram_we  out  1  write enable
- sram_addr  out  ADDR_W-2  word address
- sram_wmask  out  4  byte write mask
- sram_wdata  out  32  write data
- sram_rdata  in  32  read data, valid the cycle after a read sram_req

Behaviour:
- Reset (async, active-high):
  - FIFO and pipeline stage cleared; count=0, pend=0.
  - d_valid=0, a_ready=0 while reset is asserted; all d_* payload outputs 0.
  - In-flight responses are dropped. sram_req is combinational, so it is 0 during reset.
- Credits:
  - a_ready = (count + pend) < DEPTH.
  - Registered terms only; no combinational path from d_ready to a_ready.
- Accept (fire = a_valid & a_ready) at cycle T:
  - Illegal request = opcode not in {0,1,4}, OR a_param≠0, OR a_size>2, OR address not aligned to 2^a_size.
  - Legal: sram_req=1 in the same cycle (combinational from fire); sram_addr=a_address[ADDR_W-1:2]; sram_we=(opcode≠4); sram_wmask=a_mask for Puts, 0 for Get; sram_wdata=a_data.
  - Illegal: sram_req=0.
  - Stage register captures {opcode, size, source, denied}; pend=1.
- T+1:
  - Stage enqueues into the FIFO. For Get, the FIFO entry's data field = sram_rdata (0 if denied).
  - pend clears unless a new request fires in the same cycle.
- D output:
  - d_valid = FIFO non-empty. Earliest d_valid is T+2.
  - Head entry holds stable until d_ready; entries dequeue in order.
- Response encoding:
  - Get → d_opcode=1; Put → d_opcode=0.
  - d_corrupt = denied & (d_opcode==1).
  - d_data = 0 when d_opcode==0.
- Simultaneous enqueue and dequeue: allowed; count unchanged.
- Full FIFO: a_ready=0 when count+pend=DEPTH. Credit accounting guarantees no enqueue is ever lost.
- Pointers wrap modulo DEPTH. DEPTH need not be a power of two.
- Masks are not checked against size; the slave writes exactly a_mask.

Test Plan:
- PutFull addr 0x40, mask 0xF, data 0xDEADBEEF, then Get addr 0x40 → AccessAck(source echoed) then AccessAckData d_data=0xDEADBEEF; sram_addr=0x10 both times.
- PutPartial addr 0x44, mask 0x2, data 0x0000AB00 over a prior word 0x11223344 → subsequent Get returns 0x1122AB44.
- Get a_size=2 at addr 0x42 → no sram_req; d_opcode=1, d_denied=1, d_corrupt=1, d_data=0. Also cover opcode 2 (Arithmetic) → d_opcode=0, d_denied=1, d_corrupt=0.
- Back-to-back Gets for 10 cycles with d_ready=1 → a_ready stays 1; 10 responses returned in order.
- d_ready held 0 → exactly 3 requests accepted, then a_ready=0. Raising d_ready for 1 cycle reopens a_ready the next cycle.
- Assert reset with 2 responses queued and 1 pending → d_valid=0 immediately; after reset release, a_ready=1 and no stale responses appear.
